// File: rtl/lcd_timing_ctrl.sv
// LCD scanline/frame timing generator: dot and line counters, STAT mode FSM,
// render/interrupt pulses and CPU OAM/VRAM access blocking.
module lcd_timing_ctrl #(
  parameter int unsigned DOTS_PER_LINE   = 456,
  parameter int unsigned LINES_PER_FRAME = 154,
  parameter int unsigned VISIBLE_LINES   = 144,
  parameter int unsigned OAM_DOTS        = 80,
  parameter int unsigned XFER_DOTS       = 172
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_en,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       lyc_match,
  output logic       drawline,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       cpu_oam_block,
  output logic       cpu_vram_block
);

  localparam int unsigned DOT_W    = 9;
  localparam int unsigned LY_W     = 8;
  localparam int unsigned XFER_END = OAM_DOTS + XFER_DOTS;

  typedef enum logic [2:0] {
    S_OFF, S_OAM, S_XFER, S_HBLANK, S_VBLANK
  } state_t;

  state_t           state, state_nxt;
  logic [DOT_W-1:0] dot, dot_nxt;
  logic [LY_W-1:0]  ly_nxt;
  logic [1:0]       mode_nxt;
  logic             line_end, frame_end;
  logic             lyc_match_nxt, drawline_nxt, vblank_nxt;
  logic             stat_line, stat_line_nxt, stat_irq_nxt;
  logic             oam_block_nxt, vram_block_nxt;

  // Dot/line counters advance only while running; OFF pins both at zero.
  always_comb begin
    dot_nxt   = '0;
    ly_nxt    = '0;
    line_end  = (dot == DOT_W'(DOTS_PER_LINE - 1));
    frame_end = line_end && (ly == LY_W'(LINES_PER_FRAME - 1));
    if (lcd_en && state != S_OFF) begin
      if (line_end) begin
        dot_nxt = '0;
        ly_nxt  = frame_end ? '0 : ly + LY_W'(1);
      end else begin
        dot_nxt = dot + DOT_W'(1);
        ly_nxt  = ly;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_OFF;
    else        state <= state_nxt;
  end

  // Next state and the values the registered outputs take with it.
  always_comb begin
    state_nxt = state;
    if (!lcd_en) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF:    state_nxt = S_OAM;
        S_OAM:    if (dot_nxt == DOT_W'(OAM_DOTS)) state_nxt = S_XFER;
        S_XFER:   if (dot_nxt == DOT_W'(XFER_END)) state_nxt = S_HBLANK;
        S_HBLANK: if (line_end)
                    state_nxt = (ly_nxt == LY_W'(VISIBLE_LINES)) ? S_VBLANK : S_OAM;
        S_VBLANK: if (frame_end) state_nxt = S_OAM;
        default:  state_nxt = S_OFF;
      endcase
    end

    mode_nxt = 2'd0;
    case (state_nxt)
      S_OAM:    mode_nxt = 2'd2;
      S_XFER:   mode_nxt = 2'd3;
      S_VBLANK: mode_nxt = 2'd1;
      default:  mode_nxt = 2'd0;
    endcase

    drawline_nxt   = (state_nxt == S_XFER) && (dot_nxt == DOT_W'(OAM_DOTS));
    vblank_nxt     = (state_nxt == S_VBLANK) && (ly_nxt == LY_W'(VISIBLE_LINES)) &&
                     (dot_nxt == '0);
    lyc_match_nxt  = lcd_en && (ly == lyc);
    oam_block_nxt  = (state_nxt == S_OAM) || (state_nxt == S_XFER);
    vram_block_nxt = (state_nxt == S_XFER);

    // Shared STAT line; OFF holds it low so no edge can be seen while disabled.
    stat_line_nxt = (state_nxt != S_OFF) &&
                    (((state_nxt == S_HBLANK) && stat_ie[0]) ||
                     ((state_nxt == S_VBLANK) && stat_ie[1]) ||
                     ((state_nxt == S_OAM)    && stat_ie[2]) ||
                     (lyc_match_nxt           && stat_ie[3]));
    stat_irq_nxt  = stat_line_nxt && !stat_line;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot            <= '0;
      ly             <= '0;
      mode           <= 2'd0;
      lyc_match      <= 1'b0;
      drawline       <= 1'b0;
      vblank_irq     <= 1'b0;
      stat_irq       <= 1'b0;
      stat_line      <= 1'b0;
      cpu_oam_block  <= 1'b0;
      cpu_vram_block <= 1'b0;
    end else begin
      dot            <= dot_nxt;
      ly             <= ly_nxt;
      mode           <= mode_nxt;
      lyc_match      <= lyc_match_nxt;
      drawline       <= drawline_nxt;
      vblank_irq     <= vblank_nxt;
      stat_irq       <= stat_irq_nxt;
      stat_line      <= stat_line_nxt;
      cpu_oam_block  <= oam_block_nxt;
      cpu_vram_block <= vram_block_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Bench for lcd_timing_ctrl: directed frame/line checks plus randomized
// enable/lyc/stat_ie traffic against an arithmetic timing model.
module tb_lcd_timing_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_en = 1'b0;
  logic [7:0] lyc = 8'd0;
  logic [3:0] stat_ie = 4'd0;
  logic [7:0] ly;
  logic [1:0] mode;
  logic       lyc_match, drawline, vblank_irq, stat_irq;
  logic       cpu_oam_block, cpu_vram_block;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: cycles since enable, previous-cycle line and STAT line.
  bit         m_run = 1'b0;
  int         m_t = 0;
  bit         m_sl = 1'b0;
  logic [7:0] e_ly = 8'd0;
  logic [1:0] e_mode = 2'd0;
  logic       e_lm = 1'b0, e_dl = 1'b0, e_vb = 1'b0, e_si = 1'b0;
  logic       e_oam = 1'b0, e_vram = 1'b0;

  lcd_timing_ctrl dut (
    .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lyc(lyc), .stat_ie(stat_ie),
    .ly(ly), .mode(mode), .lyc_match(lyc_match), .drawline(drawline),
    .vblank_irq(vblank_irq), .stat_irq(stat_irq),
    .cpu_oam_block(cpu_oam_block), .cpu_vram_block(cpu_vram_block)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_run = 1'b0; m_t = 0; m_sl = 1'b0;
    e_ly = 8'd0; e_mode = 2'd0; e_lm = 1'b0; e_dl = 1'b0; e_vb = 1'b0;
    e_si = 1'b0; e_oam = 1'b0; e_vram = 1'b0;
  endfunction

  // One clock edge of the reference: position from elapsed cycles, mode from dot ranges.
  function automatic void model_step();
    int  d, l;
    bit  sl;
    if (!lcd_en) begin
      model_reset();
      return;
    end
    e_lm = (e_ly == lyc);
    if (!m_run) begin
      m_run = 1'b1;
      m_t   = 0;
    end else begin
      m_t++;
    end
    d = m_t % 456;
    l = (m_t / 456) % 154;
    e_ly = 8'(l);
    if (l >= 144)     e_mode = 2'd1;
    else if (d < 80)  e_mode = 2'd2;
    else if (d < 252) e_mode = 2'd3;
    else              e_mode = 2'd0;
    e_dl   = (l < 144) && (d == 80);
    e_vb   = (l == 144) && (d == 0);
    e_oam  = (e_mode == 2'd2) || (e_mode == 2'd3);
    e_vram = (e_mode == 2'd3);
    sl = ((e_mode == 2'd0) && stat_ie[0]) || ((e_mode == 2'd1) && stat_ie[1]) ||
         ((e_mode == 2'd2) && stat_ie[2]) || (e_lm && stat_ie[3]);
    e_si = sl && !m_sl;
    m_sl = sl;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [15:0] got, exp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    got = {ly, mode, lyc_match, drawline, vblank_irq, stat_irq, cpu_oam_block, cpu_vram_block};
    exp = {e_ly, e_mode, e_lm, e_dl, e_vb, e_si, e_oam, e_vram};
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL cycle t=%0d outputs observed %h expected %h", m_t, got, exp);
    end
  endtask

  int n_dl, n_vb, n_si;
  logic [15:0] allout;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    allout = {ly, mode, lyc_match, drawline, vblank_irq, stat_irq, cpu_oam_block, cpu_vram_block};
    check("reset_outputs", 32'(allout), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // First frame: bring-up timing, LYC interrupt, hblank interrupts, frame totals.
    lyc = 8'd10; stat_ie = 4'b1000; lcd_en = 1'b1;
    tick();
    check("en_mode", 32'(mode), 32'd2);
    check("en_ly", 32'(ly), 32'd0);
    n_dl = 32'(drawline); n_vb = 32'(vblank_irq); n_si = 32'(stat_irq);
    for (int c = 1; c <= 70224; c++) begin
      tick();
      if (c == 80) begin
        check("xfer_mode", 32'(mode), 32'd3);
        check("xfer_drawline", 32'(drawline), 32'd1);
      end
      if (c == 252) check("hblank_mode", 32'(mode), 32'd0);
      if (c == 456) check("line1_ly", 32'(ly), 32'd1);
      if (c == 4561) check("lyc_irq", 32'(stat_irq), 32'd1);
      if (c == 5016) check("lyc_match_hold", 32'(lyc_match), 32'd1);
      if (c == 5017) begin
        check("lyc_ly11", 32'(ly), 32'd11);
        check("lyc_match_fall", 32'(lyc_match), 32'd0);
      end
      if (c < 20*456 + 100) n_si += 32'(stat_irq);
      if (c == 20*456 + 100) begin
        check("lyc_irq_count", 32'(n_si), 32'd1);
        stat_ie = 4'b0101;
        n_si = 0;
      end
      if (c >= 21*456 && c < 30*456 && stat_irq) begin
        n_si++;
        check("hb_irq_dot", 32'(c % 456), 32'd252);
        check("hb_irq_mode", 32'(mode), 32'd0);
      end
      if (c == 30*456) check("hb_irq_count", 32'(n_si), 32'd9);
      if (c < 70224) begin
        n_dl += 32'(drawline);
        if (vblank_irq) begin
          n_vb++;
          check("vblank_ly", 32'(ly), 32'd144);
        end
      end
      if (c == 70224) begin
        check("frame_drawlines", 32'(n_dl), 32'd144);
        check("frame_vblanks", 32'(n_vb), 32'd1);
        check("frame_wrap_ly", 32'(ly), 32'd0);
      end
    end

    // Second frame: drop lcd_en in mid-transfer on line 50, then re-enable.
    for (int c = 0; c < 50*456 + 100; c++) tick();
    check("pre_drop_ly", 32'(ly), 32'd50);
    check("pre_drop_mode", 32'(mode), 32'd3);
    lcd_en = 1'b0;
    tick();
    check("drop_ly", 32'(ly), 32'd0);
    check("drop_mode", 32'(mode), 32'd0);
    check("drop_blocks", 32'({cpu_oam_block, cpu_vram_block}), 32'd0);
    tick();
    lcd_en = 1'b1;
    tick();
    check("reen_ly", 32'(ly), 32'd0);
    check("reen_mode", 32'(mode), 32'd2);
    repeat (456) begin
      tick();
      if (m_t == 80) check("reen_drawline", 32'(drawline), 32'd1);
      if (m_t == 456) check("reen_ly1", 32'(ly), 32'd1);
    end

    // Randomized enable/lyc/stat_ie traffic.
    for (int blk = 0; blk < 30; blk++) begin
      lyc     = 8'($urandom_range(0, 3));
      stat_ie = 4'($urandom);
      lcd_en  = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < 50; k++) tick();
    end

    // Asynchronous reset in the middle of a running line.
    lcd_en = 1'b1; stat_ie = 4'b0100;
    repeat (20) tick();
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    #1;
    allout = {ly, mode, lyc_match, drawline, vblank_irq, stat_irq, cpu_oam_block, cpu_vram_block};
    check("async_reset_outputs", 32'(allout), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_mode", 32'(mode), 32'd2);
    check("post_reset_ly", 32'(ly), 32'd0);
    repeat (100) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
